// File: rtl/ib_mul_seq.sv
// Sequential shift-add multiplier: WA x WB operands, BPC multiplier bits retired per cycle,
// per-operation signed/unsigned mode, start/done handshake with busy flag.
module ib_mul_seq #(
  parameter int unsigned WA  = 8,
  parameter int unsigned WB  = 8,
  parameter int unsigned BPC = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_signed,
  input  logic [WA-1:0]     i_a,
  input  logic [WB-1:0]     i_b,
  output logic [WA+WB-1:0]  o_c,
  output logic              o_done,
  output logic              o_busy
);

  localparam int unsigned WP = WA + WB;
  localparam int unsigned N  = WB / BPC;
  localparam int unsigned CW = $clog2(N + 1);

  if ((WB % BPC) != 0 || WA < 2 || WB < 2) begin : g_bad_params
    $error("ib_mul_seq: WB must be a multiple of BPC and WA, WB must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state, state_nx;
  logic [WP-1:0]   a_sh;
  logic [WP-1:0]   acc;
  logic [WB-1:0]   b_sh;
  logic [CW-1:0]   cnt;
  logic            neg;
  logic [WA-1:0]   a_mag;
  logic [WB-1:0]   b_mag;
  logic [WP-1:0]   pp;

  // Magnitudes fit unsigned in WA/WB bits, including -2^(W-1).
  always_comb begin
    a_mag = (i_signed && i_a[WA-1]) ? (~i_a + WA'(1)) : i_a;
    b_mag = (i_signed && i_b[WB-1]) ? (~i_b + WB'(1)) : i_b;
    pp    = a_sh * WP'(b_sh[BPC-1:0]);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_start) state_nx = RUN;
      RUN:     if (cnt == CW'(N - 1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Multiplicand is pre-shifted each iteration instead of tracking a bit offset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      o_c    <= '0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            a_sh <= WP'(a_mag);
            b_sh <= b_mag;
            neg  <= i_signed & (i_a[WA-1] ^ i_b[WB-1]);
            acc  <= '0;
            cnt  <= '0;
          end
        end
        RUN: begin
          acc  <= acc + pp;
          a_sh <= a_sh << BPC;
          b_sh <= b_sh >> BPC;
          cnt  <= cnt + CW'(1);
        end
        FIX: begin
          o_c    <= neg ? (~acc + WP'(1)) : acc;
          o_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ib_mul_seq.sv
// Self-checking bench for ib_mul_seq: 8x8/BPC=1 and 12x6/BPC=2 instances against an
// arithmetic reference model, plus handshake, reset and back-to-back sequences.
module tb_ib_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        st8, s8;
  logic [7:0]  a8, b8;
  logic [15:0] c8;
  logic        done8, busy8;
  logic        st12, s12;
  logic [11:0] a12;
  logic [5:0]  b12;
  logic [17:0] c12;
  logic        done12, busy12;

  int checks = 0;
  int errors = 0;

  ib_mul_seq u8 (
    .i_clk(clk), .i_rst(rst), .i_start(st8), .i_signed(s8),
    .i_a(a8), .i_b(b8), .o_c(c8), .o_done(done8), .o_busy(busy8)
  );

  ib_mul_seq #(.WA(12), .WB(6), .BPC(2)) u12 (
    .i_clk(clk), .i_rst(rst), .i_start(st12), .i_signed(s12),
    .i_a(a12), .i_b(b12), .o_c(c12), .o_done(done12), .o_busy(busy12)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input bit s, input longint unsigned a,
                                          input longint unsigned b, input int wa, input int wb);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[wa-1]) sa = sa - (longint'(1) << wa);
    if (s && b[wb-1]) sb = sb - (longint'(1) << wb);
    p = sa * sb;
    return 64'(p) & ((64'd1 << (wa + wb)) - 64'd1);
  endfunction

  // Waits for done on the 8x8 instance, scrambling its operands every cycle.
  task automatic wait8(output logic [15:0] c, output int lat);
    c = 'x;
    lat = 0;
    while (lat < 20) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      s8 = 1'($urandom);
      @(posedge clk); #1;
      lat++;
      if (done8) begin
        c = c8;
        break;
      end
    end
  endtask

  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                     output logic [15:0] c, output int lat);
    @(negedge clk);
    s8 = s; a8 = a; b8 = b; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    wait8(c, lat);
  endtask

  task automatic op12(input logic s, input logic [11:0] a, input logic [5:0] b,
                      output logic [17:0] c, output int lat);
    @(negedge clk);
    s12 = s; a12 = a; b12 = b; st12 = 1'b1;
    @(posedge clk); #1;
    st12 = 1'b0;
    c = 'x;
    lat = 0;
    while (lat < 20) begin
      a12 = 12'($urandom);
      b12 = 6'($urandom);
      s12 = 1'($urandom);
      @(posedge clk); #1;
      lat++;
      if (done12) begin
        c = c12;
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vec[8];
    logic [15:0] c;
    logic [17:0] cw;
    int          lat;
    int          cnt;
    logic        s;
    logic [7:0]  a, b;
    logic [11:0] a2;
    logic [5:0]  b2;

    vec[0] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vec[1] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    vec[2] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vec[3] = '{1'b1, 8'h00, 8'h80, 16'h0000};
    vec[4] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vec[5] = '{1'b0, 8'h03, 8'h05, 16'h000F};
    vec[6] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
    vec[7] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};

    rst = 1'b1;
    st8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0;
    st12 = 1'b0; s12 = 1'b0; a12 = '0; b12 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_c", 64'(c8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_busy12", 64'(busy12), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vec[i]) begin
      op8(vec[i].sgn, vec[i].a, vec[i].b, c, lat);
      check($sformatf("vec%0d_c", i), 64'(c), 64'(vec[i].exp));
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'd9);
    end
    @(posedge clk); #1;
    check("done_single_cycle", 64'(done8), 64'd0);

    for (int i = 0; i < 1500; i++) begin
      s = 1'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      op8(s, a, b, c, lat);
      check("rnd8_c", 64'(c), ref_mul(s, 64'(a), 64'(b), 8, 8));
      check("rnd8_lat", 64'(lat), 64'd9);
    end

    for (int i = 0; i < 300; i++) begin
      s = 1'($urandom);
      a2 = 12'($urandom);
      b2 = 6'($urandom);
      op12(s, a2, b2, cw, lat);
      check("rnd12_c", 64'(cw), ref_mul(s, 64'(a2), 64'(b2), 12, 6));
      check("rnd12_lat", 64'(lat), 64'd4);
    end

    // Start pulsed at E3 with other operands must be ignored.
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd100; s8 = 1'b0; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    check("busy_after_e0", 64'(busy8), 64'd1);
    c = 'x;
    lat = 0;
    while (lat < 20) begin
      if (lat == 2) begin
        st8 = 1'b1; a8 = 8'd7; b8 = 8'd3; s8 = 1'b1;
      end else begin
        st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (done8) begin
        c = c8;
        break;
      end
    end
    st8 = 1'b0;
    check("ign_c", 64'(c), 64'd20000);
    check("ign_lat", 64'(lat), 64'd9);
    check("busy_in_done", 64'(busy8), 64'd0);

    // Start in the done cycle is accepted back-to-back.
    a8 = 8'd12; b8 = 8'd13; s8 = 1'b0; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    check("b2b_hold_prev", 64'(c8), 64'd20000);
    check("b2b_busy", 64'(busy8), 64'd1);
    wait8(c, lat);
    check("b2b_c", 64'(c), 64'd156);
    check("b2b_lat", 64'(lat), 64'd9);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd100; s8 = 1'b0; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_c", 64'(c8), 64'd0);
    check("arst_done", 64'(done8), 64'd0);
    check("arst_busy", 64'(busy8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    a8 = 8'd3; b8 = 8'd5; s8 = 1'b0; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    wait8(c, lat);
    check("post_rst_c", 64'(c), 64'd15);
    check("post_rst_lat", 64'(lat), 64'd9);

    // Start held high: one accepted operation per N+2 cycles.
    @(negedge clk);
    a8 = 8'd7; b8 = 8'd9; s8 = 1'b0; st8 = 1'b1;
    cnt = 0;
    repeat (33) begin
      @(posedge clk); #1;
      if (done8) begin
        cnt++;
        check("held_c", 64'(c8), 64'd63);
      end
    end
    st8 = 1'b0;
    check("held_count", 64'(cnt), 64'd3);
    repeat (15) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
